rgb_led_driver: RTL and testbench
=================================

# rgb_led_driver

Downstream stage of the 2-bit comparator that produces the one-hot red/green/blue result. It glitch-filters the comparator's colour outputs and holds the accepted colour. It then drives a physical RGB LED with a PWM brightness that is updated glitch-free at period boundaries. It also flags illegal multi-hot inputs.

## Interface
- PWM_BITS, 8: width of PWM counter and duty; period = 2**PWM_BITS cycles
- HOLD_CYCLES, 16: consecutive stable cycles required before a colour is accepted; legal range 1 .. 2**16-1
- clk  input  1  system clock, rising edge
- rst_n  input  1  one clock domain; reset is asynchronous, active-low
- en  input  1  run enable; low forces LEDs dark
- red_in, green_in, blue_in  input  1 each  comparator colour outputs, synchronous to clk
- duty  input  PWM_BITS  on-time in cycles per period
- led_r, led_g, led_b  output  1 each  registered PWM drive
- valid  output  1  one-cycle pulse: new colour accepted
- err  output  1  level: stable multi-hot input present

## Operation
- Input register: smp <= {red_in, green_in, blue_in} every cycle.
- Filter: if smp != cand, then cand <= smp and stab_cnt <= 0. Otherwise stab_cnt increments, saturating at HOLD_CYCLES-1.
- Accept: when stab_cnt == HOLD_CYCLES-1, cand is one-hot or zero, and cand != pend:
  - pend <= cand
  - valid <= 1 for one cycle
- A stable colour pulses valid exactly once.
- Zero (all inputs low) is a legal colour, COL_OFF.
- Multi-hot: when stab_cnt == HOLD_CYCLES-1 and cand is multi-hot:
  - err <= 1
  - pend is unchanged and no valid pulse is issued
  - err clears on the edge where cand changes
- FSM states: OFF and RUN.
  - OFF → RUN when en = 1.
  - RUN → OFF when en = 0.
- OFF behaviour: pwm_cnt = 0, LEDs 0, cur_color <= pend, cur_duty <= duty. The filter keeps running.
- RUN behaviour: pwm_cnt free-runs 0 .. 2**PWM_BITS-1 and wraps.
- Period boundary: at the edge where pwm_cnt == max, cur_color <= pend and cur_duty <= duty. Mid-period changes never affect the current period.
- LED outputs: led_x <= (state == RUN) & cur_color[x] & (pwm_cnt < cur_duty).
- Duty edge cases:
  - duty = 0: LED never lit.
  - duty = max: LED lit for all but one cycle of each period.

## Timing
- Reset: every output is 0. smp, cand, pend, cur_color, cur_duty, stab_cnt and pwm_cnt are all 0. State is OFF.
- Reset asserted mid-operation clears all outputs immediately and asynchronously.
- Accept latency (edge 1 = the first edge that samples the new input):
  - valid/pend update on edge HOLD_CYCLES+2
  - err asserts on that same edge for a multi-hot input
- Input glitches shorter than HOLD_CYCLES+1 samples are never accepted.
- LED latency: a new pend or duty reaches the LEDs at the first edge after the next period wrap.
- Simultaneous accept and wrap on the same edge: the wrap loads the old pend. The new colour appears one period later.
- en falls: LEDs are 0 after the next edge and pwm_cnt is 0.
- en rises: the first RUN cycle has pwm_cnt = 0 with the colour and duty loaded while in OFF.

## Structure
- Package rgb_pkg contains:
  - typedef color_t (3 bits, order {r,g,b})
  - constants COL_OFF = 3'b000, COL_R = 3'b100, COL_G = 3'b010, COL_B = 3'b001
  - function is_onehot0(color_t)
- Sub-module pwm_gen (parameter PWM_BITS). It owns pwm_cnt, cur_duty, the wrap strobe and compare, and outputs pwm_on and wrap.
- The top level holds the filter, the FSM and the LED gating.

## Test plan
Bench parameters: PWM_BITS=4, HOLD_CYCLES=4, duty=4, en=1 unless stated.
- Accept red: red_in=1 held → valid is a single pulse on edge 6. Starting from the next wrap, led_r is high for pwm_cnt 0..3 of every 16 cycles; led_g and led_b stay 0.
- Glitch: green_in high for 3 cycles, then back → no valid pulse, and the red pattern is unchanged.
- Multi-hot: red_in=blue_in=1 for 10 cycles → err=1 from edge 6 until the edge after the inputs change; pend stays red and no valid pulse occurs.
- Duty change mid-period, 4 → 12 → current period keeps 4 lit cycles, the next period has 12. Then duty=0 → zero lit cycles from the following period.
- en=0 mid-period → all LEDs 0 after one edge. en=1 again → the period restarts at pwm_cnt=0 with the correct colour.
- rst_n pulsed low mid-period → all outputs 0 immediately. After release, the LEDs stay dark until a colour is re-accepted.

Source files
------------

// File: rtl/rgb_led_driver_pkg.sv
// Shared types, colour constants and helpers for the RGB LED driver.
package rgb_pkg;

  typedef logic [2:0] color_t;  // {r, g, b}

  localparam color_t COL_OFF = 3'b000;
  localparam color_t COL_R   = 3'b100;
  localparam color_t COL_G   = 3'b010;
  localparam color_t COL_B   = 3'b001;

  typedef enum logic {StOff, StRun} state_t;

  // True for zero or exactly one bit set.
  function automatic logic is_onehot0(color_t c);
    return (c & (c - 3'd1)) == 3'b000;
  endfunction

endpackage

// File: rtl/rgb_led_driver_if.sv
// Colour inputs, run control, duty and LED/status outputs of the RGB LED driver.
interface rgb_led_driver_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic                en;
  logic                red_in;
  logic                green_in;
  logic                blue_in;
  logic [PWM_BITS-1:0] duty;
  logic                led_r;
  logic                led_g;
  logic                led_b;
  logic                valid;
  logic                err;

  modport master (
    output en, red_in, green_in, blue_in, duty,
    input  led_r, led_g, led_b, valid, err
  );

  modport slave (
    input  en, red_in, green_in, blue_in, duty,
    output led_r, led_g, led_b, valid, err
  );
endinterface

// File: rtl/rgb_led_driver_pwm_gen.sv
// PWM period counter with duty latched only at period boundaries (or while idle).
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_pwm_on,
  output logic                o_wrap
);

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_cur_duty;

  assign o_wrap   = i_run && (r_cnt == '1);
  assign o_pwm_on = r_cnt < r_cur_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_cur_duty <= '0;
    end else if (!i_run) begin
      // Idle: park at zero so the first running cycle starts a fresh period.
      r_cnt      <= '0;
      r_cur_duty <= i_duty;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (o_wrap) r_cur_duty <= i_duty;
    end
  end

endmodule

// File: rtl/rgb_led_driver.sv
// Glitch-filters the comparator colour, holds the accepted colour and drives a PWM RGB LED.
module rgb_led_driver
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input logic              clk,
  input logic              rst_n,
  rgb_led_driver_if.slave  bus
);

  localparam logic [15:0] StabMax = 16'(HOLD_CYCLES - 1);

  color_t      r_smp;
  color_t      r_cand;
  color_t      r_pend;
  color_t      r_cur_color;
  logic [15:0] r_stab_cnt;
  logic        r_valid;
  logic        r_err;
  state_t      r_state;
  logic [2:0]  r_led;

  color_t w_in;
  logic   w_same;
  logic   w_stable;
  logic   w_accept;
  logic   w_run;
  logic   w_wrap;
  logic   w_pwm_on;

  assign w_in     = {bus.red_in, bus.green_in, bus.blue_in};
  assign w_same   = (r_smp == r_cand);
  // Requiring the sample to still match keeps a glitch of exactly HOLD_CYCLES samples out.
  assign w_stable = w_same && (r_stab_cnt == StabMax);
  assign w_accept = w_stable && is_onehot0(r_cand) && (r_cand != r_pend);
  assign w_run    = (r_state == StRun) && bus.en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp      <= COL_OFF;
      r_cand     <= COL_OFF;
      r_pend     <= COL_OFF;
      r_stab_cnt <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_smp   <= w_in;
      r_valid <= w_accept;
      if (!w_same) begin
        r_cand     <= r_smp;
        r_stab_cnt <= '0;
        r_err      <= 1'b0;
      end else begin
        if (r_stab_cnt != StabMax) r_stab_cnt <= r_stab_cnt + 16'd1;
        if (w_stable && !is_onehot0(r_cand)) r_err <= 1'b1;
      end
      if (w_accept) r_pend <= r_cand;
    end
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (w_run),
    .i_duty   (bus.duty),
    .o_pwm_on (w_pwm_on),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StOff;
      r_cur_color <= COL_OFF;
      r_led       <= 3'b000;
    end else begin
      case (r_state)
        StOff: begin
          r_cur_color <= r_pend;
          r_led       <= 3'b000;
          if (bus.en) r_state <= StRun;
        end
        StRun: begin
          if (!bus.en) begin
            r_state     <= StOff;
            r_cur_color <= r_pend;
            r_led       <= 3'b000;
          end else begin
            if (w_wrap) r_cur_color <= r_pend;
            r_led <= r_cur_color & {3{w_pwm_on}};
          end
        end
        default: r_state <= StOff;
      endcase
    end
  end

  assign bus.led_r = r_led[2];
  assign bus.led_g = r_led[1];
  assign bus.led_b = r_led[0];
  assign bus.valid = r_valid;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_rgb_led_driver.sv
// Directed self-checking bench for rgb_led_driver (PWM_BITS=4, HOLD_CYCLES=4).
module tb_rgb_led_driver;
  import rgb_pkg::*;

  localparam int unsigned PwmBits    = 4;
  localparam int unsigned HoldCycles = 4;
  localparam int          Period     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  rgb_led_driver_if #(.PWM_BITS(PwmBits)) bus ();

  rgb_led_driver #(
    .PWM_BITS    (PwmBits),
    .HOLD_CYCLES (HoldCycles)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int e        = 0;  // edges since the last reset release
  int base     = 1;  // edge after which pwm_cnt is 0 in the first RUN cycle

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rgb(input color_t c);
    {bus.red_in, bus.green_in, bus.blue_in} = c;
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_led"}, {bus.led_r, bus.led_g, bus.led_b}, 3'b000);
    check_eq({tag, "_valid"}, bus.valid, 1'b0);
    check_eq({tag, "_err"}, bus.err, 1'b0);
  endtask

  // Runs n edges; the LED colour/duty in effect is fixed across the span.
  task automatic run_span(input int n, input color_t col, input int d, input int v_edge,
                          input int err_lo, input int err_hi);
    for (int i = 0; i < n; i++) begin
      logic lit;
      tick();
      e++;
      lit = (e > base) && (((e - base - 1) % Period) < d);
      check_eq($sformatf("led@%0d", e), {bus.led_r, bus.led_g, bus.led_b}, col & {3{lit}});
      check_eq($sformatf("valid@%0d", e), bus.valid, (e == v_edge));
      check_eq($sformatf("err@%0d", e), bus.err, (e >= err_lo) && (e <= err_hi));
    end
  endtask

  initial begin
    bus.en   = 1'b0;
    bus.duty = 4'd4;
    set_rgb(COL_OFF);
    #1 rst_n = 1'b0;
    #1 check_dark("reset");
    tick();
    tick();
    check_dark("reset_hold");

    // Accept red: valid on edge 6, first lit period after the wrap at edge 17.
    rst_n = 1'b1;
    bus.en = 1'b1;
    set_rgb(COL_R);
    e = 0;
    base = 1;
    run_span(17, COL_OFF, 4, 6, 0, -1);
    run_span(21, COL_R, 4, -1, 0, -1);

    // Glitches of 3 and of exactly HOLD_CYCLES samples are rejected.
    set_rgb(COL_G);
    run_span(3, COL_R, 4, -1, 0, -1);
    set_rgb(COL_R);
    run_span(9, COL_R, 4, -1, 0, -1);
    set_rgb(COL_G);
    run_span(4, COL_R, 4, -1, 0, -1);
    set_rgb(COL_R);
    run_span(12, COL_R, 4, -1, 0, -1);

    // Multi-hot for 10 samples starting at edge 67: err on 72..77.
    set_rgb(COL_R | COL_B);
    run_span(10, COL_R, 4, -1, 72, 77);
    set_rgb(COL_R);
    run_span(24, COL_R, 4, -1, 72, 77);

    // Duty 4 -> 12 mid-period, then 0, then max.
    bus.duty = 4'd12;
    run_span(13, COL_R, 4, -1, 0, -1);
    run_span(5, COL_R, 12, -1, 0, -1);
    bus.duty = 4'd0;
    run_span(11, COL_R, 12, -1, 0, -1);
    run_span(21, COL_R, 0, -1, 0, -1);
    bus.duty = 4'd15;
    run_span(11, COL_R, 0, -1, 0, -1);
    run_span(4, COL_R, 15, -1, 0, -1);
    bus.duty = 4'd4;
    run_span(12, COL_R, 15, -1, 0, -1);
    run_span(2, COL_R, 4, -1, 0, -1);

    // en low mid-period, then high: period restarts at pwm_cnt 0.
    bus.en = 1'b0;
    run_span(5, COL_R, 0, -1, 0, -1);
    bus.en = 1'b1;
    base = 185;
    run_span(19, COL_R, 4, -1, 0, -1);

    // Asynchronous reset while lit; LEDs stay dark until red is re-accepted.
    #2 rst_n = 1'b0;
    #1 check_dark("rst_async");
    tick();
    check_dark("rst_mid_hold");
    rst_n = 1'b1;
    e = 0;
    base = 1;
    run_span(17, COL_OFF, 4, 6, 0, -1);
    run_span(8, COL_R, 4, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
